// File: rtl/ssc_sequencer.sv
// Round-robin command sequencer that shares one loadable counter among NREQ requesters.
// A granted command either loads the counter (jump) or advances it N times (burst).
module ssc_sequencer #(
  parameter int NREQ = 3,
  parameter int W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*W-1:0]       req_arg,
  input  logic                    halt,
  input  logic [W-1:0]            cnt_q,
  output logic                    cnt_adv,
  output logic                    cnt_jmp,
  output logic [W-1:0]            cnt_in,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [W-1:0]            done_val
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] ONE_N = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JUMP  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_r, state_nx_s;
  logic [IDW-1:0] ptr_r, id_r, grant_id_s, cand_s;
  logic [W-1:0]   arg_r, rem_r, rem_nx_s, grant_arg_s;
  logic           grant_any_s, grant_op_s, accept_s;

  // Round-robin pick: scanning downward leaves the nearest valid requester above the pointer.
  always_comb begin
    grant_id_s = {IDW{1'b0}};
    cand_s     = {IDW{1'b0}};
    for (int k = NREQ; k >= 1; k--) begin
      cand_s     = IDW'((32'(ptr_r) + 32'(k)) % 32'(NREQ));
      grant_id_s = req_valid[cand_s] ? cand_s : grant_id_s;
    end
  end

  // Select the grantee's op and argument.
  always_comb begin
    grant_op_s  = 1'b0;
    grant_arg_s = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      grant_op_s  = (grant_id_s == IDW'(i)) ? req_op[i] : grant_op_s;
      grant_arg_s = (grant_id_s == IDW'(i)) ? req_arg[i*W +: W] : grant_arg_s;
    end
  end

  assign grant_any_s = |req_valid;
  assign accept_s    = (state_r == ST_IDLE) && grant_any_s;
  assign req_ready   = (accept_s && !rst) ? (ONE_N << grant_id_s) : {NREQ{1'b0}};

  // Next-state and counter strobe decode.
  always_comb begin
    state_nx_s = state_r;
    rem_nx_s   = rem_r;
    cnt_adv    = 1'b0;
    cnt_jmp    = 1'b0;
    cnt_in     = {W{1'b0}};
    busy       = 1'b1;
    done       = 1'b0;
    done_id    = {IDW{1'b0}};
    done_val   = {W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept_s) begin
          rem_nx_s = grant_arg_s;
          if (grant_op_s) begin
            state_nx_s = ST_JUMP;
          end else if (grant_arg_s != {W{1'b0}}) begin
            state_nx_s = ST_BURST;
          end else begin
            state_nx_s = ST_DONE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_JUMP: begin
        cnt_jmp    = 1'b1;
        cnt_in     = arg_r;
        state_nx_s = ST_DONE;
      end
      ST_BURST: begin
        cnt_adv = !halt;
        if (!halt) begin
          rem_nx_s   = rem_r - ONE_W;
          state_nx_s = (rem_r == ONE_W) ? ST_DONE : ST_BURST;
        end else begin
          state_nx_s = ST_BURST;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        done_id    = id_r;
        done_val   = cnt_q;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer and latched command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= IDW'(NREQ - 1);
      id_r    <= {IDW{1'b0}};
      arg_r   <= {W{1'b0}};
      rem_r   <= {W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      rem_r   <= rem_nx_s;
      if (accept_s) begin
        ptr_r <= grant_id_s;
        id_r  <= grant_id_s;
        arg_r <= grant_arg_s;
      end
    end
  end

endmodule

// File: tb/tb_ssc_sequencer.sv
// Randomized scoreboard bench for ssc_sequencer with a behavioural counter and command model.
module tb_ssc_sequencer;

  localparam int NREQ = 3;
  localparam int W    = 6;
  localparam int IDW  = $clog2(NREQ);
  localparam int MODV = 1 << W;

  logic              clk, rst, halt;
  logic [NREQ-1:0]   req_valid, req_ready, req_op;
  logic [NREQ*W-1:0] req_arg;
  logic [W-1:0]      cnt_q, cnt_in, done_val;
  logic              cnt_adv, cnt_jmp, busy, done;
  logic [IDW-1:0]    done_id;

  ssc_sequencer #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_arg(req_arg), .halt(halt), .cnt_q(cnt_q),
    .cnt_adv(cnt_adv), .cnt_jmp(cnt_jmp), .cnt_in(cnt_in), .busy(busy),
    .done(done), .done_id(done_id), .done_val(done_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The shared counter this block drives.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (cnt_jmp) cnt_q <= cnt_in;
    else if (cnt_adv) cnt_q <= cnt_q + 6'd1;
  end

  typedef struct {
    int id;
    int op;
    int arg;
    int val;
    int t;
  } exp_t;

  exp_t            sbq[$];
  exp_t            mon_e;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              ptr_m = NREQ - 1;
  int              cnt_m = 0;
  int              n_adv = 0, n_jmp = 0, n_halt = 0;
  int              mon_g;
  logic [NREQ-1:0] mon_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: per-cycle protocol rules, scoreboard push on transfer, pop on done.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      ptr_m = NREQ - 1;
      cnt_m = 0;
      n_adv = 0; n_jmp = 0; n_halt = 0;
    end else begin
      cyc++;
      chk("strobe_excl", 32'(cnt_adv & cnt_jmp), 32'd0);
      if (!cnt_jmp) chk("cnt_in_idle", 32'(cnt_in), 32'd0);
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("busy", 32'(busy), 32'(sbq.size() != 0));
      if (done) begin
        chk("done_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("done_id", 32'(done_id), 32'(mon_e.id));
          chk("done_val", 32'(done_val), 32'(mon_e.val));
          chk("adv_count", 32'(n_adv), 32'(mon_e.op ? 0 : mon_e.arg));
          chk("jmp_count", 32'(n_jmp), 32'(mon_e.op));
          chk("latency", 32'(cyc - mon_e.t),
              32'(mon_e.op ? 2 : (mon_e.arg == 0 ? 1 : mon_e.arg + 1 + n_halt)));
        end
      end else begin
        chk("done_id_zero", 32'(done_id), 32'd0);
        chk("done_val_zero", 32'(done_val), 32'd0);
        if (sbq.size() != 0) begin
          n_adv  += int'(cnt_adv);
          n_jmp  += int'(cnt_jmp);
          n_halt += int'(halt);
        end
      end
      mon_hs = req_valid & req_ready;
      if (mon_hs != '0) begin
        mon_g = rr_pick(req_valid, ptr_m);
        chk("grant", 32'(mon_hs), 32'd1 << mon_g);
        chk("grant_while_busy", 32'(sbq.size()), 32'd0);
        mon_e.id  = mon_g;
        mon_e.op  = int'(req_op[mon_g]);
        mon_e.arg = int'(req_arg[mon_g*W +: W]);
        mon_e.val = mon_e.op ? mon_e.arg : (cnt_m + mon_e.arg) % MODV;
        mon_e.t   = cyc;
        sbq.push_back(mon_e);
        cnt_m = mon_e.val;
        ptr_m = mon_g;
        n_adv = 0; n_jmp = 0; n_halt = 0;
      end
    end
  end

  task automatic submit(input int i, input logic op, input int arg);
    req_op[i]          = op;
    req_arg[i*W +: W]  = W'(arg);
    req_valid[i]       = 1'b1;
  endtask

  // Run until every raised request is accepted and its done has been seen.
  task automatic drain(input int halt_pct);
    logic [NREQ-1:0] hs;
    int budget = 0;
    while ((req_valid != '0 || sbq.size() != 0) && budget < 500) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
      halt = ($urandom_range(0, 99) < halt_pct);
      budget++;
    end
    halt = 1'b0;
    if (budget >= 500) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=<500", budget);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "sequencer stalled");
    end
  endtask

  initial begin
    logic [NREQ-1:0] hs;
    int n;
    rst = 1'b1; halt = 1'b0;
    req_valid = '0; req_op = '0; req_arg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", 32'({cnt_adv, cnt_jmp}), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    submit(0, 1'b1, 42);            // jump 0x2A
    drain(0);
    submit(2, 1'b1, 60);
    drain(0);
    submit(1, 1'b0, 5);             // 60 + 5 wraps to 1
    drain(0);
    repeat (2) begin
      submit(0, 1'b1, 1); submit(1, 1'b1, 2); submit(2, 1'b1, 3);
      drain(0);
    end
    submit(0, 1'b0, 4);             // burst with halts mixed in
    drain(45);
    submit(1, 1'b0, 0);             // empty burst
    drain(50);

    // Abort a 10-long burst after three advances.
    submit(2, 1'b0, 10);
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (cnt_adv) n++;
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~hs;
    end
    chk("adv_before_rst", 32'(n), 32'd3);
    rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({cnt_adv, cnt_jmp}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    submit(0, 1'b1, 7); submit(1, 1'b1, 8); submit(2, 1'b1, 9);
    drain(0);

    // Random rounds of simultaneous commands.
    repeat (60) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) submit(i, 1'b1, $urandom_range(0, MODV - 1));
          else submit(i, 1'b0, $urandom_range(0, 12));
        end
      end
      drain(25);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
